// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI receiver: opcodes, address modes,
// command FSM states and reset defaults for the configuration registers.
package oled_pkg;

  localparam int BYTE_W = 8;

  // Addressing modes for framebuffer pointer advance
  typedef enum logic [1:0] {
    AM_HORIZ = 2'b00,
    AM_VERT  = 2'b01,
    AM_PAGE  = 2'b10
  } addr_mode_t;

  // Command decoder states: waiting for an opcode, or for its arguments
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } cmd_state_t;

  // Single-byte opcodes (flag value carried in the opcode itself)
  localparam logic [7:0] OP_SEG_REMAP0  = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1  = 8'hA1;
  localparam logic [7:0] OP_COM_NORM    = 8'hC0;
  localparam logic [7:0] OP_COM_REV     = 8'hC8;
  localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;

  // One-argument opcodes
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;

  // Two-argument opcodes
  localparam logic [7:0] OP_COL_RANGE   = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;

  // Configuration power-up values
  localparam logic [7:0] CONTRAST_RST   = 8'h7F;
  localparam logic [7:0] PRECHARGE_RST  = 8'h22;

  // True for any opcode that is followed by at least one argument byte
  function automatic logic takes_args(input logic [7:0] op);
    return (op == OP_CONTRAST)    || (op == OP_PRECHARGE) ||
           (op == OP_CHARGE_PUMP) || (op == OP_ADDR_MODE) ||
           (op == OP_COL_RANGE)   || (op == OP_PAGE_RANGE);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Serial byte deserializer: synchronizes spi_clk/mosi/dc into clk, detects
// spi_clk rising edges, shifts mosi in MSB first and flags each full byte.
module spi_byte_rx
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              mosi,
  input  logic              dc,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_dc,
  output logic              byte_valid
);

  // Each stage carries {spi_clk, mosi, dc} so all three see equal delay
  logic [2:0] sync_stage [SYNC_STAGES];
  logic       clk_s;
  logic       mosi_s;
  logic       dc_s;
  logic       clk_prev;
  logic       rise;
  logic [BYTE_W-2:0] shift;
  logic [2:0]        bit_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = {spi_clk, mosi, dc};
      end else begin : g_next
        assign stage_in = sync_stage[gi-1];
      end

      // One synchronizer flop per input per stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_stage[gi] <= 3'b000;
        else     sync_stage[gi] <= stage_in;
      end
    end
  endgenerate

  assign clk_s  = sync_stage[SYNC_STAGES-1][2];
  assign mosi_s = sync_stage[SYNC_STAGES-1][1];
  assign dc_s   = sync_stage[SYNC_STAGES-1][0];
  assign rise   = clk_s & ~clk_prev;

  // Edge detect, shift register, bit counter and completed-byte capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev   <= 1'b0;
      shift      <= '0;
      bit_cnt    <= 3'd0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      clk_prev   <= clk_s;
      byte_valid <= 1'b0;
      if (rise) begin
        shift   <= {shift[BYTE_W-3:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        // dc is taken with the last bit so a host may flip it mid-stream
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shift, mosi_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// OLED controller front end: decodes the command/data byte stream from the
// SPI deserializer into configuration registers and framebuffer writes with
// auto-advancing page/column pointers.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int PAGES       = 8,
  parameter int COLS        = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_clk,
  input  logic                     mosi,
  input  logic                     dc,
  output logic                     wr_en,
  output logic [$clog2(PAGES)-1:0] wr_page,
  output logic [$clog2(COLS)-1:0]  wr_col,
  output logic [7:0]               wr_data,
  output logic                     display_on,
  output logic                     seg_remap,
  output logic                     com_reverse,
  output logic                     entire_on,
  output logic                     charge_pump,
  output logic [7:0]               contrast,
  output logic [7:0]               precharge,
  output logic [1:0]               addr_mode,
  output logic                     cmd_err
);

  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(COLS);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);

  logic [7:0]    rx_byte;
  logic          rx_dc;
  logic          rx_valid;

  cmd_state_t    state;
  logic [7:0]    opcode;
  logic [CW-1:0] arg1;

  logic [CW-1:0] col_start;
  logic [CW-1:0] col_end;
  logic [PW-1:0] page_start;
  logic [PW-1:0] page_end;
  logic [CW-1:0] col;
  logic [PW-1:0] page;

  logic          col_wrap;
  logic          page_wrap;
  logic [CW-1:0] col_inc;
  logic [PW-1:0] page_inc;
  logic [CW-1:0] col_adv;
  logic [PW-1:0] page_adv;

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_byte_rx (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .mosi      (mosi),
    .dc        (dc),
    .byte_data (rx_byte),
    .byte_dc   (rx_dc),
    .byte_valid(rx_valid)
  );

  // A pointer wraps at its window end or at the array edge, whichever it
  // meets first, so a start-above-end window still cycles back to start
  assign col_wrap  = (col == col_end) || (col == COL_MAX);
  assign page_wrap = (page == page_end) || (page == PAGE_MAX);
  assign col_inc   = col_wrap  ? col_start  : col + 1'b1;
  assign page_inc  = page_wrap ? page_start : page + 1'b1;

  // Next pointer position after a data write, by addressing mode
  always_comb begin
    col_adv  = col;
    page_adv = page;
    case (addr_mode)
      AM_VERT: begin
        page_adv = page_inc;
        if (page_wrap) col_adv = col_inc;
      end
      AM_PAGE: begin
        col_adv = col_inc;
      end
      default: begin
        col_adv = col_inc;
        if (col_wrap) page_adv = page_inc;
      end
    endcase
  end

  // Framebuffer write strobe, registered one cycle after the data byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_page <= '0;
      wr_col  <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_en <= rx_valid & rx_dc;
      if (rx_valid && rx_dc) begin
        wr_page <= page;
        wr_col  <= col;
        wr_data <= rx_byte;
      end
    end
  end

  // Command FSM, configuration registers and address pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      opcode      <= 8'h00;
      arg1        <= '0;
      cmd_err     <= 1'b0;
      display_on  <= 1'b0;
      seg_remap   <= 1'b0;
      com_reverse <= 1'b0;
      entire_on   <= 1'b0;
      charge_pump <= 1'b0;
      contrast    <= CONTRAST_RST;
      precharge   <= PRECHARGE_RST;
      addr_mode   <= AM_PAGE;
      col_start   <= '0;
      col_end     <= COL_MAX;
      page_start  <= '0;
      page_end    <= PAGE_MAX;
      col         <= '0;
      page        <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (rx_valid) begin
        if (rx_dc) begin
          // Data always lands; a pending command it interrupts is dropped
          col  <= col_adv;
          page <= page_adv;
          if (state != ST_IDLE) begin
            cmd_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end else begin
          case (state)
            ST_IDLE: begin
              opcode <= rx_byte;
              case (rx_byte)
                OP_SEG_REMAP0, OP_SEG_REMAP1: seg_remap   <= rx_byte[0];
                OP_COM_NORM,   OP_COM_REV:    com_reverse <= rx_byte[3];
                OP_ENTIRE_OFF, OP_ENTIRE_ON:  entire_on   <= rx_byte[0];
                OP_DISP_OFF,   OP_DISP_ON:    display_on  <= rx_byte[0];
                default: begin
                  if (takes_args(rx_byte)) state   <= ST_ARG1;
                  else                     cmd_err <= 1'b1;
                end
              endcase
            end
            ST_ARG1: begin
              arg1  <= rx_byte[CW-1:0];
              state <= ST_IDLE;
              case (opcode)
                OP_CONTRAST:    contrast    <= rx_byte;
                OP_PRECHARGE:   precharge   <= rx_byte;
                OP_CHARGE_PUMP: charge_pump <= rx_byte[2];
                OP_ADDR_MODE: begin
                  // 11 is not a mode; keep the current one and flag it
                  if (rx_byte[1:0] == 2'b11) cmd_err   <= 1'b1;
                  else                       addr_mode <= rx_byte[1:0];
                end
                default: state <= ST_ARG2;
              endcase
            end
            ST_ARG2: begin
              state <= ST_IDLE;
              if (opcode == OP_COL_RANGE) begin
                col_start <= arg1;
                col_end   <= rx_byte[CW-1:0];
                col       <= arg1;
              end else begin
                page_start <= arg1[PW-1:0];
                page_end   <= rx_byte[PW-1:0];
                page       <= arg1[PW-1:0];
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: directed scenarios plus a randomized command/data
// stream checked against a byte-level reference model.
module tb_oled_spi_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       dc = 1'b0;
  logic       wr_en;
  logic [2:0] wr_page;
  logic [6:0] wr_col;
  logic [7:0] wr_data;
  logic       display_on, seg_remap, com_reverse, entire_on, charge_pump;
  logic [7:0] contrast, precharge;
  logic [1:0] addr_mode;
  logic       cmd_err;

  int tests_run = 0;
  int tests_failed = 0;
  int err_cnt = 0;
  int co_cnt = 0;
  logic [17:0] wq[$];

  // reference model state
  int         m_contrast, m_pre, m_mode, m_state;
  int         m_cstart, m_cend, m_pstart, m_pend, m_col, m_page, m_err;
  logic       m_disp, m_seg, m_com, m_ent, m_cp;
  logic [7:0] m_op, m_arg;
  logic [17:0] eq[$];

  logic [7:0] singles [8] = '{8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'hA4, 8'hA5, 8'hAE, 8'hAF};
  logic [7:0] one_arg [4] = '{8'h81, 8'hD9, 8'h8D, 8'h20};
  logic [7:0] unknown [4] = '{8'h00, 8'h55, 8'h3C, 8'hE3};

  always #5 clk = ~clk;

  oled_spi_rx #(.PAGES(8), .COLS(128), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .mosi(mosi), .dc(dc),
    .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
    .display_on(display_on), .seg_remap(seg_remap), .com_reverse(com_reverse),
    .entire_on(entire_on), .charge_pump(charge_pump), .contrast(contrast),
    .precharge(precharge), .addr_mode(addr_mode), .cmd_err(cmd_err)
  );

  // capture writes and error pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wq.push_back({wr_page, wr_col, wr_data});
      if (cmd_err) err_cnt++;
      if (cmd_err && wr_en) co_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); spi_clk = 1'b0; mosi = b[i]; dc = d;
      @(negedge clk);
      @(negedge clk); spi_clk = 1'b1;
      @(negedge clk);
    end
    @(negedge clk); spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, d, 8);
  endtask

  task automatic settle;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; spi_clk = 1'b0; mosi = 1'b0; dc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    tests_run++; if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    tests_run++; if ({wr_page, wr_col, wr_data} !== 18'h0) begin tests_failed++; $display("FAIL reset_wr_bus: got %h want 0", {wr_page, wr_col, wr_data}); end
    tests_run++; if (contrast !== 8'h7F) begin tests_failed++; $display("FAIL reset_contrast: got %h want 7f", contrast); end
    tests_run++; if (precharge !== 8'h22) begin tests_failed++; $display("FAIL reset_precharge: got %h want 22", precharge); end
    tests_run++; if (addr_mode !== 2'b10) begin tests_failed++; $display("FAIL reset_addr_mode: got %b want 10", addr_mode); end
    tests_run++; if ({display_on, seg_remap, com_reverse, entire_on, charge_pump} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 00000", {display_on, seg_remap, com_reverse, entire_on, charge_pump}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_config;
    int e0;
    e0 = err_cnt; wq.delete();
    send_byte(8'h8D, 0); send_byte(8'h14, 0);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h81, 0); send_byte(8'hCF, 0);
    send_byte(8'hD9, 0); send_byte(8'hF1, 0);
    settle();
    tests_run++; if (charge_pump !== 1'b1) begin tests_failed++; $display("FAIL cfg_charge_pump: got %b want 1", charge_pump); end
    tests_run++; if (addr_mode !== 2'b00) begin tests_failed++; $display("FAIL cfg_addr_mode: got %b want 00", addr_mode); end
    tests_run++; if (contrast !== 8'hCF) begin tests_failed++; $display("FAIL cfg_contrast: got %h want cf", contrast); end
    tests_run++; if (precharge !== 8'hF1) begin tests_failed++; $display("FAIL cfg_precharge: got %h want f1", precharge); end
    tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL cfg_no_err: got %0d pulses want 0", err_cnt - e0); end
    tests_run++; if (wq.size() !== 0) begin tests_failed++; $display("FAIL cfg_no_write: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_horizontal;
    logic [7:0] d [1024];
    int bad, first_bad, e0, n;
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0);
    settle();
    e0 = err_cnt; wq.delete();
    for (int i = 0; i < 1024; i++) begin
      d[i] = 8'($urandom);
      send_byte(d[i], 1);
    end
    send_byte(8'h5A, 1);
    settle();
    tests_run++; if (wq.size() !== 1025) begin tests_failed++; $display("FAIL horiz_count: got %0d writes want 1025", wq.size()); end
    n = (wq.size() < 1024) ? wq.size() : 1024;
    bad = 0; first_bad = -1;
    for (int i = 0; i < n; i++) begin
      if (wq[i] !== {3'(i / 128), 7'(i % 128), d[i]}) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL horiz_order: got %0d wrong writes (first at %0d) want 0", bad, first_bad); end
    if (wq.size() == 1025) begin
      tests_run++; if (wq[1024] !== {3'd0, 7'd0, 8'h5A}) begin tests_failed++; $display("FAIL horiz_wrap: got %h want %h", wq[1024], {3'd0, 7'd0, 8'h5A}); end
    end
    tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL horiz_no_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_page_mode;
    logic [7:0] d0, d1, d2;
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    send_byte(8'h20, 0); send_byte(8'h02, 0);
    send_byte(8'h22, 0); send_byte(8'h03, 0); send_byte(8'h07, 0);
    send_byte(8'h21, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    settle();
    wq.delete();
    send_byte(d0, 1); send_byte(d1, 1); send_byte(d2, 1);
    settle();
    tests_run++; if (wq.size() !== 3) begin tests_failed++; $display("FAIL page_count: got %0d writes want 3", wq.size()); end
    if (wq.size() == 3) begin
      tests_run++; if (wq[0] !== {3'd3, 7'h7E, d0}) begin tests_failed++; $display("FAIL page_w0: got %h want %h", wq[0], {3'd3, 7'h7E, d0}); end
      tests_run++; if (wq[1] !== {3'd3, 7'h7F, d1}) begin tests_failed++; $display("FAIL page_w1: got %h want %h", wq[1], {3'd3, 7'h7F, d1}); end
      tests_run++; if (wq[2] !== {3'd3, 7'h7E, d2}) begin tests_failed++; $display("FAIL page_w2: got %h want %h", wq[2], {3'd3, 7'h7E, d2}); end
    end
  endtask

  task automatic test_abort;
    int e0, c0;
    do_reset();
    e0 = err_cnt; c0 = co_cnt; wq.delete();
    send_byte(8'h81, 0); send_byte(8'hAA, 1);
    settle();
    tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL abort_err: got %0d pulses want 1", err_cnt - e0); end
    tests_run++; if (co_cnt - c0 !== 1) begin tests_failed++; $display("FAIL abort_same_cycle: got %0d coincident pulses want 1", co_cnt - c0); end
    tests_run++; if (wq.size() !== 1 || wq[0] !== {3'd0, 7'd0, 8'hAA}) begin
      tests_failed++; $display("FAIL abort_write: got %0d writes first %h want 1 write %h", wq.size(), (wq.size() > 0) ? wq[0] : 18'h0, {3'd0, 7'd0, 8'hAA}); end
    tests_run++; if (contrast !== 8'h7F) begin tests_failed++; $display("FAIL abort_contrast: got %h want 7f", contrast); end
    send_byte(8'hA1, 0);
    settle();
    tests_run++; if (seg_remap !== 1'b1 || contrast !== 8'h7F) begin
      tests_failed++; $display("FAIL abort_idle: got seg_remap=%b contrast=%h want 1/7f", seg_remap, contrast); end
  endtask

  task automatic test_unknown;
    int e0;
    e0 = err_cnt;
    send_byte(8'h55, 0);
    settle();
    tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL unknown_err: got %0d pulses want 1", err_cnt - e0); end
    send_byte(8'hAF, 0);
    settle();
    tests_run++; if (display_on !== 1'b1) begin tests_failed++; $display("FAIL unknown_then_af: got display_on=%b want 1", display_on); end
    tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL unknown_err_once: got %0d pulses want 1", err_cnt - e0); end
  endtask

  task automatic test_bad_addr_mode;
    int e0;
    e0 = err_cnt;
    send_byte(8'h20, 0); send_byte(8'h03, 0);
    settle();
    tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL mode11_err: got %0d pulses want 1", err_cnt - e0); end
    tests_run++; if (addr_mode !== 2'b10) begin tests_failed++; $display("FAIL mode11_keep: got %b want 10", addr_mode); end
  endtask

  task automatic test_reset_mid_byte;
    int e0;
    send_bits(8'hFF, 1, 5);
    do_reset();
    tests_run++; if (seg_remap !== 1'b0) begin tests_failed++; $display("FAIL midrst_seg_cleared: got %b want 0", seg_remap); end
    e0 = err_cnt; wq.delete();
    send_byte(8'hA1, 0);
    settle();
    tests_run++; if (seg_remap !== 1'b1) begin tests_failed++; $display("FAIL midrst_seg_remap: got %b want 1", seg_remap); end
    tests_run++; if (wq.size() !== 0 || err_cnt - e0 !== 0) begin
      tests_failed++; $display("FAIL midrst_spurious: got %0d writes %0d errs want 0/0", wq.size(), err_cnt - e0); end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset;
    m_contrast = 8'h7F; m_pre = 8'h22; m_mode = 2; m_state = 0;
    m_cstart = 0; m_cend = 127; m_pstart = 0; m_pend = 7; m_col = 0; m_page = 0;
    m_disp = 0; m_seg = 0; m_com = 0; m_ent = 0; m_cp = 0; m_err = 0;
    m_op = 8'h00; m_arg = 8'h00;
    eq.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    bit cw, pw;
    int cn, pn;
    if (d) begin
      eq.push_back({3'(m_page), 7'(m_col), b});
      cw = (m_col == m_cend) || (m_col == 127);
      pw = (m_page == m_pend) || (m_page == 7);
      cn = cw ? m_cstart : m_col + 1;
      pn = pw ? m_pstart : m_page + 1;
      if (m_mode == 0) begin m_col = cn; if (cw) m_page = pn; end
      else if (m_mode == 1) begin m_page = pn; if (pw) m_col = cn; end
      else m_col = cn;
      if (m_state != 0) begin m_err++; m_state = 0; end
    end else if (m_state == 0) begin
      m_op = b;
      if (b == 8'hA0 || b == 8'hA1) m_seg = b[0];
      else if (b == 8'hC0 || b == 8'hC8) m_com = b[3];
      else if (b == 8'hA4 || b == 8'hA5) m_ent = b[0];
      else if (b == 8'hAE || b == 8'hAF) m_disp = b[0];
      else if (b inside {8'h81, 8'hD9, 8'h8D, 8'h20, 8'h21, 8'h22}) m_state = 1;
      else m_err++;
    end else if (m_state == 1) begin
      m_arg = b; m_state = 0;
      if (m_op == 8'h81) m_contrast = b;
      else if (m_op == 8'hD9) m_pre = b;
      else if (m_op == 8'h8D) m_cp = b[2];
      else if (m_op == 8'h20) begin
        if (b[1:0] == 2'b11) m_err++; else m_mode = b[1:0];
      end else m_state = 2;
    end else begin
      m_state = 0;
      if (m_op == 8'h21) begin m_cstart = m_arg % 128; m_cend = b % 128; m_col = m_cstart; end
      else begin m_pstart = m_arg % 8; m_pend = b % 8; m_page = m_pstart; end
    end
  endtask

  task automatic emit(input logic [7:0] b, input logic d);
    model_byte(b, d);
    send_byte(b, d);
  endtask

  task automatic test_random;
    int e0, bad, n;
    do_reset();
    model_reset();
    e0 = err_cnt; wq.delete();
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: emit(8'($urandom), 1);
        4: emit(singles[$urandom_range(0, 7)], 0);
        5: begin emit(one_arg[$urandom_range(0, 3)], 0); emit(8'($urandom), 0); end
        6: begin emit(8'h21, 0); emit(8'($urandom), 0); emit(8'($urandom), 0); end
        7: begin emit(8'h22, 0); emit(8'($urandom), 0); emit(8'($urandom), 0); end
        8: emit(unknown[$urandom_range(0, 3)], 0);
        default: begin emit(($urandom_range(0, 1) == 1) ? 8'h81 : 8'h21, 0); emit(8'($urandom), 1); end
      endcase
    end
    settle();
    tests_run++; if (wq.size() !== eq.size()) begin tests_failed++; $display("FAIL rand_write_count: got %0d want %0d", wq.size(), eq.size()); end
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (wq[i] !== eq[i]) bad++;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL rand_writes: got %0d mismatching writes want 0", bad); end
    tests_run++; if (err_cnt - e0 !== m_err) begin tests_failed++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt - e0, m_err); end
    tests_run++; if ({contrast, precharge, addr_mode} !== {8'(m_contrast), 8'(m_pre), 2'(m_mode)}) begin
      tests_failed++; $display("FAIL rand_cfg_bytes: got %h/%h/%b want %h/%h/%b", contrast, precharge, addr_mode, 8'(m_contrast), 8'(m_pre), 2'(m_mode)); end
    tests_run++; if ({display_on, seg_remap, com_reverse, entire_on, charge_pump} !== {m_disp, m_seg, m_com, m_ent, m_cp}) begin
      tests_failed++; $display("FAIL rand_flags: got %b want %b", {display_on, seg_remap, com_reverse, entire_on, charge_pump}, {m_disp, m_seg, m_com, m_ent, m_cp}); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_horizontal();
    test_page_mode();
    test_abort();
    test_unknown();
    test_bad_addr_mode();
    test_reset_mid_byte();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
